dram_axi_line_port: RTL
=======================

Name: dram_axi_line_port

Overview:
Single-clock successor to the core-side DRAM controller. It accepts one core read or write at a time and issues it as an AXI4 master transaction toward the MIG AXI slave. Reads fetch a whole line of LINE_BEATS beats as an INCR burst, for cache-line fills; writes are single-beat with byte strobes. Width, line length and address size are parametrised. Sticky error reporting and an optional last-line read buffer are features the previous generation lacks.

Parameters:
ADDR_W, 28, AXI address width (bytes)
DATA_W, 128, AXI data width; a multiple of 32, power of two
LINE_BEATS, 1, beats per read burst; power of two, 1..16; LINE_W = DATA_W*LINE_BEATS

Ports:
i_clk  in  1  clock for core side and AXI side
i_rst_x  in  1  asynchronous reset, active-low
i_init_calib_complete  in  1  MIG calibration done
i_rd_en  in  1  read request, sampled only in IDLE
i_wr_en  in  1  write request, sampled only in IDLE; wins over i_rd_en
i_addr  in  32  byte address
i_data  in  32  write data
i_mask  in  4  byte mask, 1 = byte NOT written
o_data  out  LINE_W  read line; beat k at [k*DATA_W +: DATA_W]
o_data_valid  out  1  one-cycle pulse when o_data holds a new line
o_busy  out  1  high in every state except IDLE
o_err  out  1  sticky AXI error flag
s_axi_awaddr  out  ADDR_W  write address
s_axi_awlen  out  8  always 0
s_axi_awsize  out  3  log2(DATA_W/8)
s_axi_awburst  out  2  2'b01
s_axi_awvalid  out  1  write address valid
s_axi_awready  in  1  write address ready
s_axi_wdata  out  DATA_W  write data
s_axi_wstrb  out  DATA_W/8  write strobes
s_axi_wlast  out  1  always 1
s_axi_wvalid  out  1  write data valid
s_axi_wready  in  1  write data ready
s_axi_bresp  in  2  write response
s_axi_bvalid  in  1  write response valid
s_axi_bready  out  1  write response ready
s_axi_araddr  out  ADDR_W  read address
s_axi_arlen  out  8  LINE_BEATS-1
s_axi_arsize  out  3  log2(DATA_W/8)
s_axi_arburst  out  2  2'b01
s_axi_arvalid  out  1  read address valid
s_axi_arready  in  1  read address ready
s_axi_rdata  in  DATA_W  read data
s_axi_rresp  in  2  read response
s_axi_rlast  in  1  last read beat
s_axi_rvalid  in  1  read data valid
s_axi_rready  out  1  read data ready
(AXI IDs, lock, cache, prot and qos are tied off at top level: IDs 0, cache 4'b0011, others 0.)

Behaviour:
- Reset (async, i_rst_x=0): state CALIB. All valid and ready outputs 0, o_data 0, o_data_valid 0, o_err 0, o_busy 1. Asserting reset mid-transaction aborts it at once; the interconnect is reset together with this block.
- States are CALIB, IDLE, AR, RD, WR, B (plus HIT, see Optional Feature).
- CALIB -> IDLE on the first cycle i_init_calib_complete=1.
- IDLE: a request seen in cycle N latches the address, data and mask. Requests arriving while busy are ignored, not queued.
  - Write (wins if both asserted) -> WR; AWVALID and WVALID go high in cycle N+1.
  - Read -> AR; ARVALID goes high in cycle N+1.
- AR: araddr = i_addr with its low log2(LINE_W/8) bits cleared. Hold ARVALID until ARREADY, then -> RD with beat counter = 0.
- RD: RREADY=1. Each RVALID beat is written to o_data slice [cnt] and cnt increments. When the beat with cnt=LINE_BEATS-1 is accepted: o_data_valid=1 in the next cycle and state -> IDLE.
  - RLAST arriving early, or missing on the final beat, sets o_err. Completion is still decided by the count alone.
- WR: awaddr = i_addr aligned to DATA_W/8 bytes. wdata = i_data replicated DATA_W/32 times. wstrb = (~i_mask) << (4 * i_addr[log2(DATA_W/8)-1:2]). AW and W handshakes complete independently, in either order or in the same cycle; each valid drops after its own handshake. -> B once both are done.
- B: BREADY=1. On BVALID -> IDLE.
- o_err is set by any rresp or bresp other than 2'b00 and cleared only by reset. An error does not abort the transaction.
- o_data holds its value until the next line is delivered. Writes never change o_data.

Optional Feature:
Macro DRAM_LINEBUF_EN.
- Defined: a one-line buffer (tag = i_addr[ADDR_W-1:log2(LINE_W/8)] plus a valid bit) is loaded by every completed read.
  - A read whose tag hits and is valid goes IDLE -> HIT -> IDLE with no AXI traffic: o_data_valid pulses in cycle N+1, o_busy is high for exactly one cycle.
  - A write that hits updates the unmasked bytes of o_data and still performs the AXI write (write-through).
  - Any error response clears valid.
- Undefined: every read issues an AXI burst; no HIT state.

Test Plan:
- Calibration gate: i_init_calib_complete=0, pulse i_rd_en -> no ARVALID, o_busy=1. Set calibration to 1 -> IDLE, o_busy=0.
- Burst read, LINE_BEATS=4, DATA_W=128: read 0x0000_0134 -> araddr=0x100, arlen=3. Beats 0xA..,0xB..,0xC..,0xD.. land in o_data[127:0]..[511:384]; one o_data_valid pulse.
- Strobed write, DATA_W=128: addr 0x0000_0048, data 0x11223344, mask 4'b0100 -> awaddr=0x40, wstrb=16'h0B00, wdata=4x0x11223344. WREADY before AWREADY -> single B handshake, then IDLE.
- Error: bresp=2'b10 -> o_err=1 and stays 1 through later OKAY transactions until reset.
- Reset mid-burst: drop i_rst_x after beat 1 of 4 -> ARVALID/RREADY=0 immediately, o_data=0, state CALIB.
- DRAM_LINEBUF_EN: read 0x100, then read 0x104 -> no ARVALID, o_data_valid in the next cycle. Write 0x108 (mask 0) then read 0x100 -> buffer shows the new bytes.

Source files
------------

// File: rtl/dram_axi_line_port.sv
// Core-side DRAM port issuing AXI4 line reads and strobed single-beat writes.
// Optional one-line read buffer with write-through: DRAM_LINEBUF_EN.
module dram_axi_line_port #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int LINE_BEATS = 1,
  localparam int LINE_W    = DATA_W * LINE_BEATS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_x,
  input  logic                  i_init_calib_complete,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_data,
  input  logic [3:0]            i_mask,
  output logic [LINE_W-1:0]     o_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [ADDR_W-1:0]     s_axi_awaddr,
  output logic [7:0]            s_axi_awlen,
  output logic [2:0]            s_axi_awsize,
  output logic [1:0]            s_axi_awburst,
  output logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  output logic [DATA_W-1:0]     s_axi_wdata,
  output logic [DATA_W/8-1:0]   s_axi_wstrb,
  output logic                  s_axi_wlast,
  output logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  output logic                  s_axi_bready,
  output logic [ADDR_W-1:0]     s_axi_araddr,
  output logic [7:0]            s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_W-1:0]     s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BYTE_L = $clog2(STRB_W);
  localparam int LINE_L = $clog2(LINE_W / 8);
  localparam int LANES  = DATA_W / 32;
  localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  localparam logic [2:0] S_CALIB = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_AR    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_B     = 3'd5;
`ifdef DRAM_LINEBUF_EN
  localparam logic [2:0] S_HIT   = 3'd6;
  localparam int WORDS = LINE_W / 32;
  localparam int TAG_W = ADDR_W - LINE_L;
`endif

  logic [2:0]        r_state;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [3:0]        r_mask;
  logic              r_awvalid;
  logic              r_wvalid;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;
  logic              r_dv;
  logic              r_err;

  logic [31:0]       w_lane;
  logic [3:0]        w_nmask;
  logic [STRB_W-1:0] w_strb;
  logic [31:0]       w_base;
  logic              w_last;
  logic              w_aw_done;
  logic              w_w_done;
  logic              w_rerr;
  logic              w_hit;

  assign w_lane    = (r_addr >> 2) & 32'(LANES - 1);
  assign w_nmask   = ~r_mask;
  assign w_strb    = STRB_W'(w_nmask) << (w_lane * 32'd4);
  assign w_base    = 32'(r_cnt) * 32'(DATA_W);
  assign w_last    = (r_cnt == CNT_W'(LINE_BEATS - 1));
  assign w_aw_done = !r_awvalid || s_axi_awready;
  assign w_w_done  = !r_wvalid || s_axi_wready;
  assign w_rerr    = (s_axi_rresp != 2'b00);

`ifdef DRAM_LINEBUF_EN
  logic [TAG_W-1:0] r_tag;
  logic             r_tvld;
  logic             r_rerr;
  logic [31:0]      w_wbit;

  assign w_hit  = r_tvld && (r_tag == i_addr[ADDR_W-1:LINE_L]);
  assign w_wbit = ((i_addr >> 2) & 32'(WORDS - 1)) << 5;

  // Tag tracks the line held in o_data; any error response invalidates it
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_tag  <= '0;
      r_tvld <= 1'b0;
      r_rerr <= 1'b0;
    end else begin
      if (r_state == S_AR) begin
        r_rerr <= 1'b0;
      end
      if (r_state == S_RD && s_axi_rvalid) begin
        if (w_rerr) begin
          r_rerr <= 1'b1;
          r_tvld <= 1'b0;
        end
        if (w_last) begin
          r_tag  <= r_addr[ADDR_W-1:LINE_L];
          r_tvld <= !(r_rerr || w_rerr);
        end
      end
      if (r_state == S_B && s_axi_bvalid && s_axi_bresp != 2'b00) begin
        r_tvld <= 1'b0;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_state   <= S_CALIB;
      r_addr    <= '0;
      r_data    <= '0;
      r_mask    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_cnt     <= '0;
      r_line    <= '0;
      r_dv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      unique case (r_state)
        S_CALIB: begin
          if (i_init_calib_complete) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_wr_en || i_rd_en) begin
            r_addr <= i_addr;
            r_data <= i_data;
            r_mask <= i_mask;
          end
          if (i_wr_en) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR;
`ifdef DRAM_LINEBUF_EN
            if (w_hit) begin
              for (int b = 0; b < 4; b++) begin
                if (!i_mask[b]) begin
                  r_line[w_wbit + 32'(b * 8) +: 8] <= i_data[b*8 +: 8];
                end
              end
            end
`endif
          end else if (i_rd_en) begin
`ifdef DRAM_LINEBUF_EN
            if (w_hit) begin
              r_dv    <= 1'b1;
              r_state <= S_HIT;
            end else begin
              r_state <= S_AR;
            end
`else
            r_state <= S_AR;
`endif
          end
        end
        S_AR: begin
          if (s_axi_arready) begin
            r_cnt   <= '0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          if (s_axi_rvalid) begin
            r_line[w_base +: DATA_W] <= s_axi_rdata;
            r_cnt <= r_cnt + 1'b1;
            // Count decides completion; a misplaced RLAST is only reported
            if (w_rerr || (s_axi_rlast != w_last)) begin
              r_err <= 1'b1;
            end
            if (w_last) begin
              r_dv    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WR: begin
          if (s_axi_awready) begin
            r_awvalid <= 1'b0;
          end
          if (s_axi_wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_state <= S_B;
          end
        end
        S_B: begin
          if (s_axi_bvalid) begin
            if (s_axi_bresp != 2'b00) begin
              r_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
`ifdef DRAM_LINEBUF_EN
        S_HIT: begin
          r_state <= S_IDLE;
        end
`endif
        default: begin
          r_state <= S_CALIB;
        end
      endcase
    end
  end

  assign o_data       = r_line;
  assign o_data_valid = r_dv;
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;

  assign s_axi_awaddr  = ADDR_W'(r_addr & ~(32'(STRB_W) - 32'd1));
  assign s_axi_awlen   = 8'd0;
  assign s_axi_awsize  = 3'(BYTE_L);
  assign s_axi_awburst = 2'b01;
  assign s_axi_awvalid = r_awvalid;
  assign s_axi_wdata   = {LANES{r_data}};
  assign s_axi_wstrb   = w_strb;
  assign s_axi_wlast   = 1'b1;
  assign s_axi_wvalid  = r_wvalid;
  assign s_axi_bready  = (r_state == S_B);

  assign s_axi_araddr  = ADDR_W'(r_addr & ~(32'(LINE_W / 8) - 32'd1));
  assign s_axi_arlen   = 8'(LINE_BEATS - 1);
  assign s_axi_arsize  = 3'(BYTE_L);
  assign s_axi_arburst = 2'b01;
  assign s_axi_arvalid = (r_state == S_AR);
  assign s_axi_rready  = (r_state == S_RD);

endmodule
